// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-side inputs plus stage controls (stall/flush) and the
// registered writeback port.
//   master : upstream/pipeline control side (drives in_*, stall, flush)
//   slave  : mem_wb_stage (drives wb_*)
interface mem_wb_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic [2:0]            in_load_type;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_mem_read_data;
    logic [REG_ADDR_W-1:0] in_dest_reg;

    logic                  wb_valid;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_dest_reg;
    logic [DATA_W-1:0]     wb_write_data;
    logic                  wb_bad_load;
    logic [31:0]           wb_retire_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_type,
               in_alu_result, in_mem_read_data, in_dest_reg,
        input  wb_valid, wb_reg_write, wb_dest_reg, wb_write_data, wb_bad_load,
               wb_retire_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_load_type,
               in_alu_result, in_mem_read_data, in_dest_reg,
        output wb_valid, wb_reg_write, wb_dest_reg, wb_write_data, wb_bad_load,
               wb_retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and load formatter.
// Captures memory read data, ALU result and writeback control, formats
// byte/half loads, selects the writeback value and keeps a retired-instruction
// counter. All wb_* outputs are registered (1-cycle latency).
// Ports:
//   clk  : pipeline clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : mem_wb_if.slave (stall/flush, in_* MEM inputs, wb_* register-file port)
module mem_wb_stage (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.slave  bus
);
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 32;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic [DATA_W-1:0]     load_data_c;
    logic [DATA_W-1:0]     write_data_c;
    logic                  reg_write_c;
    logic                  bad_load_c;

    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic [DATA_W-1:0]     write_data;
    logic                  bad_load;
    logic [CNT_W-1:0]      retire_count;

    // Load formatter: memory returns the addressed byte in the low lane.
    // Reserved codes fall through to the LW (unchanged) default.
    always_comb begin
        load_data_c = bus.in_mem_read_data;
        case (bus.in_load_type)
            LT_LW:   load_data_c = bus.in_mem_read_data;
            LT_LH:   load_data_c = {{16{bus.in_mem_read_data[15]}}, bus.in_mem_read_data[15:0]};
            LT_LHU:  load_data_c = {16'b0, bus.in_mem_read_data[15:0]};
            LT_LB:   load_data_c = {{24{bus.in_mem_read_data[7]}}, bus.in_mem_read_data[7:0]};
            LT_LBU:  load_data_c = {24'b0, bus.in_mem_read_data[7:0]};
            default: load_data_c = bus.in_mem_read_data;
        endcase
    end

    // Writeback select and control qualification; writes to $0 are dropped.
    always_comb begin
        write_data_c = bus.in_mem_to_reg ? load_data_c : bus.in_alu_result;
        reg_write_c  = bus.in_valid & bus.in_reg_write
                     & (bus.in_dest_reg != REG_ADDR_W'(0));
        bad_load_c   = bus.in_valid & bus.in_mem_to_reg & (bus.in_load_type > LT_LBU);
    end

    // Stage registers: rst > flush > stall > capture. Flush keeps the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid        <= 1'b0;
            reg_write    <= 1'b0;
            dest_reg     <= '0;
            write_data   <= '0;
            bad_load     <= 1'b0;
            retire_count <= '0;
        end else if (bus.flush) begin
            valid        <= 1'b0;
            reg_write    <= 1'b0;
            dest_reg     <= '0;
            write_data   <= '0;
            bad_load     <= 1'b0;
        end else if (!bus.stall) begin
            valid        <= bus.in_valid;
            reg_write    <= reg_write_c;
            dest_reg     <= bus.in_dest_reg;
            write_data   <= write_data_c;
            bad_load     <= bad_load_c;
            if (bus.in_valid) begin
                retire_count <= retire_count + CNT_W'(1);
            end
        end
    end

    assign bus.wb_valid        = valid;
    assign bus.wb_reg_write    = reg_write;
    assign bus.wb_dest_reg     = dest_reg;
    assign bus.wb_write_data   = write_data;
    assign bus.wb_bad_load     = bad_load;
    assign bus.wb_retire_count = retire_count;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// stall/flush/wrap/reset sequences and randomized traffic against a
// behavioural model.
module tb_mem_wb_stage;
    logic clk;
    logic rst;

    mem_wb_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        valid;
        logic        reg_write;
        logic        mem_to_reg;
        logic [2:0]  load_type;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  dest;
    } in_t;

    typedef struct {
        in_t         i;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic        exp_bad;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Expected state of the stage
    logic        e_valid, e_rw, e_bad;
    logic [4:0]  e_dest;
    logic [31:0] e_data, e_cnt;

    // Sign/zero extension done arithmetically on the low lanes
    function automatic logic [31:0] fmt(input logic [2:0] lt, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d % 32'h100;
        h = d % 32'h10000;
        case (lt)
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4:    return b;
            default: return d;
        endcase
    endfunction

    task automatic model_edge(input in_t i, input logic r);
        if (r) begin
            e_valid = 0; e_rw = 0; e_bad = 0; e_dest = 0; e_data = 0; e_cnt = 0;
        end else if (i.flush) begin
            e_valid = 0; e_rw = 0; e_bad = 0; e_dest = 0; e_data = 0;
        end else if (!i.stall) begin
            e_valid = i.valid;
            e_rw    = i.valid && i.reg_write && (i.dest != 0);
            e_dest  = i.dest;
            e_bad   = i.valid && i.mem_to_reg && (i.load_type > 3'd4);
            e_data  = i.mem_to_reg ? fmt(i.load_type, i.mem) : i.alu;
            if (i.valid) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("wb_valid",        32'(bus.wb_valid),        32'(e_valid));
        cmp("wb_reg_write",    32'(bus.wb_reg_write),    32'(e_rw));
        cmp("wb_dest_reg",     32'(bus.wb_dest_reg),     32'(e_dest));
        cmp("wb_write_data",   bus.wb_write_data,        e_data);
        cmp("wb_bad_load",     32'(bus.wb_bad_load),     32'(e_bad));
        cmp("wb_retire_count", bus.wb_retire_count,      e_cnt);
    endtask

    task automatic drive(input in_t i, input logic r);
        rst                  = r;
        bus.stall            = i.stall;
        bus.flush            = i.flush;
        bus.in_valid         = i.valid;
        bus.in_reg_write     = i.reg_write;
        bus.in_mem_to_reg    = i.mem_to_reg;
        bus.in_load_type     = i.load_type;
        bus.in_alu_result    = i.alu;
        bus.in_mem_read_data = i.mem;
        bus.in_dest_reg      = i.dest;
    endtask

    // One clock: drive, advance model at the edge, sample 1 time unit later
    task automatic cycle(input in_t i, input logic r);
        drive(i, r);
        @(posedge clk);
        model_edge(i, r);
        #1;
        check_all();
    endtask

    function automatic in_t rand_in();
        in_t i;
        i.stall      = ($urandom_range(0, 5) == 0);
        i.flush      = ($urandom_range(0, 9) == 0);
        i.valid      = ($urandom_range(0, 3) != 0);
        i.reg_write  = $urandom_range(0, 1) == 1;
        i.mem_to_reg = $urandom_range(0, 1) == 1;
        i.load_type  = 3'($urandom_range(0, 7));
        i.alu        = $urandom;
        i.mem        = $urandom;
        i.dest       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return i;
    endfunction

    function automatic in_t mk(input logic v, input logic rw, input logic m2r,
                               input logic [2:0] lt, input logic [31:0] alu,
                               input logic [31:0] mem, input logic [4:0] dest);
        in_t i;
        i.stall = 0; i.flush = 0; i.valid = v; i.reg_write = rw; i.mem_to_reg = m2r;
        i.load_type = lt; i.alu = alu; i.mem = mem; i.dest = dest;
        return i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        in_t  t;

        vecs[0] = '{mk(1, 1, 1, 3'b011, 32'h0, 32'h000000F0, 5'd8), 32'hFFFFFFF0, 1'b1, 1'b0};
        vecs[1] = '{mk(1, 1, 1, 3'b100, 32'h0, 32'h000000F0, 5'd8), 32'h000000F0, 1'b1, 1'b0};
        vecs[2] = '{mk(1, 1, 1, 3'b001, 32'h0, 32'h12348001, 5'd3), 32'hFFFF8001, 1'b1, 1'b0};
        vecs[3] = '{mk(1, 1, 1, 3'b010, 32'h0, 32'h12348001, 5'd3), 32'h00008001, 1'b1, 1'b0};
        vecs[4] = '{mk(1, 1, 1, 3'b000, 32'h0, 32'h12348001, 5'd3), 32'h12348001, 1'b1, 1'b0};
        vecs[5] = '{mk(1, 1, 0, 3'b011, 32'hDEADBEEF, 32'h5555AAAA, 5'd9), 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[6] = '{mk(1, 1, 0, 3'b000, 32'h00000042, 32'h0, 5'd0), 32'h00000042, 1'b0, 1'b0};
        vecs[7] = '{mk(1, 1, 1, 3'b110, 32'h0, 32'hCAFE80F0, 5'd4), 32'hCAFE80F0, 1'b1, 1'b1};
        vecs[8] = '{mk(0, 1, 1, 3'b011, 32'h0, 32'h00000080, 5'd5), 32'hFFFFFF80, 1'b0, 1'b0};

        // Reset with random inputs
        for (int k = 0; k < 2; k++) cycle(rand_in(), 1'b1);
        cmp("reset_count_zero", bus.wb_retire_count, 32'h0);

        // Directed vectors: table expectations plus model on the rest
        for (int k = 0; k < 9; k++) begin
            cycle(vecs[k].i, 1'b0);
            cmp("vec_data", bus.wb_write_data, vecs[k].exp_data);
            cmp("vec_rw",   32'(bus.wb_reg_write), 32'(vecs[k].exp_rw));
            cmp("vec_bad",  32'(bus.wb_bad_load),  32'(vecs[k].exp_bad));
        end
        cmp("vec_count", bus.wb_retire_count, 32'd8);

        // Stall for 3 cycles with changing inputs: everything frozen
        for (int k = 0; k < 3; k++) begin
            t = rand_in();
            t.stall = 1; t.flush = 0; t.valid = 1;
            cycle(t, 1'b0);
            cmp("stall_count", bus.wb_retire_count, 32'd8);
        end

        // Stall and flush together: bubble, counter kept
        t = mk(1, 1, 1, 3'b000, 32'h1, 32'h2, 5'd7);
        t.stall = 1; t.flush = 1;
        cycle(t, 1'b0);
        cmp("flush_valid", 32'(bus.wb_valid), 32'd0);
        cmp("flush_count", bus.wb_retire_count, 32'd8);

        // Counter wrap from a preloaded value
        force dut.retire_count = 32'hFFFFFFFE;
        #1;
        release dut.retire_count;
        e_cnt = 32'hFFFFFFFE;
        cycle(mk(1, 1, 0, 3'b000, 32'h11, 32'h0, 5'd1), 1'b0);
        cmp("wrap_ffffffff", bus.wb_retire_count, 32'hFFFFFFFF);
        cycle(mk(1, 1, 0, 3'b000, 32'h22, 32'h0, 5'd2), 1'b0);
        cmp("wrap_zero", bus.wb_retire_count, 32'h0);
        cycle(mk(1, 1, 0, 3'b000, 32'h33, 32'h0, 5'd3), 1'b0);
        cmp("wrap_one", bus.wb_retire_count, 32'h1);

        // Reset mid-stream
        cycle(mk(1, 1, 1, 3'b011, 32'h0, 32'hFF, 5'd6), 1'b1);
        cmp("midrst_data", bus.wb_write_data, 32'h0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cycle(rand_in(), ($urandom_range(0, 49) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
